// File: rtl/uart_json_feedback_rx_if.sv
// Bundles the serial input and the parsed-frame outputs of uart_json_feedback_rx.
interface uart_json_feedback_rx_if;
   logic        uart_in;
   logic        frame_valid;
   logic [15:0] t_code;
   logic [15:0] key_value;
   logic        key_found;
   logic        framing_error;
   logic        parse_error;

   modport master (
      output uart_in,
      input  frame_valid, t_code, key_value, key_found, framing_error, parse_error
   );

   modport slave (
      input  uart_in,
      output frame_valid, t_code, key_value, key_found, framing_error, parse_error
   );
endinterface

// File: rtl/uart_json_feedback_rx.sv
// 8N1 UART receiver feeding a flat-JSON line parser that extracts "T" and one
// single-character key, presented on a one-cycle frame_valid strobe.
module uart_json_feedback_rx #(
   parameter int unsigned CLKS_PER_BIT = 50_000_000 / 115_200,
   parameter logic [7:0]  KEY_CHAR     = 8'h76,
   parameter int unsigned MAX_LEN      = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   uart_json_feedback_rx_if.slave  bus
);

   localparam int unsigned CW       = $clog2(CLKS_PER_BIT + 1);
   localparam int unsigned LW       = $clog2(MAX_LEN + 1);
   localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;

   localparam logic [1:0] RX_IDLE  = 2'd0;
   localparam logic [1:0] RX_START = 2'd1;
   localparam logic [1:0] RX_DATA  = 2'd2;
   localparam logic [1:0] RX_STOP  = 2'd3;

   localparam logic [2:0] P_WAIT_OPEN = 3'd0;
   localparam logic [2:0] P_KEY_Q     = 3'd1;
   localparam logic [2:0] P_KEY       = 3'd2;
   localparam logic [2:0] P_COLON     = 3'd3;
   localparam logic [2:0] P_VALUE     = 3'd4;
   localparam logic [2:0] P_WAIT_NL   = 3'd5;
   localparam logic [2:0] P_ERR       = 3'd6;

   localparam logic [7:0] CH_LBRACE = 8'h7B;
   localparam logic [7:0] CH_RBRACE = 8'h7D;
   localparam logic [7:0] CH_QUOTE  = 8'h22;
   localparam logic [7:0] CH_COLON  = 8'h3A;
   localparam logic [7:0] CH_COMMA  = 8'h2C;
   localparam logic [7:0] CH_MINUS  = 8'h2D;
   localparam logic [7:0] CH_DOT    = 8'h2E;
   localparam logic [7:0] CH_NL     = 8'h0A;
   localparam logic [7:0] CH_T      = 8'h54;
   localparam logic [7:0] CH_0      = 8'h30;
   localparam logic [7:0] CH_9      = 8'h39;

   logic [1:0]    sync;
   logic          rx_prev;
   logic [1:0]    rx_state;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          byte_valid;
   logic          stop_low;
   logic          bit_end;

   always_comb begin
      bit_end    = (bit_cnt == CW'(CLKS_PER_BIT - 1));
      byte_valid = (rx_state == RX_STOP) && bit_end && sync[1];
      stop_low   = (rx_state == RX_STOP) && bit_end && !sync[1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync     <= '1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         bit_cnt  <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
      end else begin
         sync    <= {sync[0], bus.uart_in};
         rx_prev <= sync[1];
         case (rx_state)
            RX_IDLE: begin
               bit_cnt <= '0;
               bit_idx <= '0;
               if (rx_prev && !sync[1]) rx_state <= RX_START;
            end
            RX_START: begin
               if (bit_cnt == CW'(HALF_BIT - 1)) begin
                  bit_cnt  <= '0;
                  rx_state <= sync[1] ? RX_IDLE : RX_DATA;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  shreg   <= {sync[1], shreg[7:1]};
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) rx_state <= RX_STOP;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            default: begin
               if (bit_end) begin
                  bit_cnt  <= '0;
                  rx_state <= RX_IDLE;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
         endcase
      end
   end

   logic [2:0]    p_state;
   logic [2:0]    p_next;
   logic [7:0]    key_char;
   logic [1:0]    key_len;
   logic [15:0]   acc;
   logic          neg;
   logic          digit_seen;
   logic          val_first;
   logic [15:0]   st_t;
   logic [15:0]   st_key;
   logic          st_found;
   logic          t_seen;
   logic [LW-1:0] line_cnt;

   logic          in_frame;
   logic          restart;
   logic          is_digit;
   logic          p_fail;
   logic          do_commit;
   logic          emit;
   logic [19:0]   acc_mult;
   logic [15:0]   acc_sat;
   logic          match_t;
   logic          match_k;

   always_comb begin
      in_frame  = (p_state != P_WAIT_OPEN) && (p_state != P_ERR);
      restart   = byte_valid && (shreg == CH_LBRACE) && (p_state != P_ERR);
      is_digit  = (shreg >= CH_0) && (shreg <= CH_9);
      acc_mult  = {4'b0, acc} * 20'd10 + {16'b0, shreg[3:0]};
      acc_sat   = (acc_mult > 20'd32767) ? 16'h7FFF : acc_mult[15:0];
      match_t   = (key_len == 2'd1) && (key_char == CH_T);
      match_k   = (key_len == 2'd1) && (key_char == KEY_CHAR);
      p_next    = p_state;
      p_fail    = 1'b0;
      do_commit = 1'b0;
      emit      = 1'b0;
      if (byte_valid) begin
         if (restart) begin
            p_next = P_KEY_Q;
         end else begin
            case (p_state)
               P_WAIT_OPEN: ;
               P_KEY_Q:     if (shreg == CH_QUOTE) p_next = P_KEY; else p_fail = 1'b1;
               P_KEY: begin
                  if (shreg == CH_QUOTE)   p_next = P_COLON;
                  else if (shreg == CH_NL) p_fail = 1'b1;
               end
               P_COLON:     if (shreg == CH_COLON) p_next = P_VALUE; else p_fail = 1'b1;
               P_VALUE: begin
                  if (is_digit || shreg == CH_DOT || (shreg == CH_MINUS && val_first)) begin
                     p_next = P_VALUE;
                  end else if ((shreg == CH_COMMA || shreg == CH_RBRACE) && digit_seen) begin
                     do_commit = 1'b1;
                     p_next    = (shreg == CH_COMMA) ? P_KEY_Q : P_WAIT_NL;
                  end else begin
                     p_fail = 1'b1;
                  end
               end
               P_WAIT_NL: begin
                  if (shreg == CH_NL && t_seen) begin
                     emit   = 1'b1;
                     p_next = P_WAIT_OPEN;
                  end else begin
                     p_fail = 1'b1;
                  end
               end
               P_ERR:   if (shreg == CH_NL) p_next = P_WAIT_OPEN;
               default: p_next = P_WAIT_OPEN;
            endcase
            if (in_frame && line_cnt >= LW'(MAX_LEN - 1)) p_fail = 1'b1;
         end
         // A rejected newline already ends the line, so there is nothing left to skip.
         if (p_fail) begin
            emit      = 1'b0;
            do_commit = 1'b0;
            p_next    = (shreg == CH_NL) ? P_WAIT_OPEN : P_ERR;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_state           <= P_WAIT_OPEN;
         key_char          <= '0;
         key_len           <= '0;
         acc               <= '0;
         neg               <= 1'b0;
         digit_seen        <= 1'b0;
         val_first         <= 1'b0;
         st_t              <= '0;
         st_key            <= '0;
         st_found          <= 1'b0;
         t_seen            <= 1'b0;
         line_cnt          <= '0;
         bus.frame_valid   <= 1'b0;
         bus.t_code        <= '0;
         bus.key_value     <= '0;
         bus.key_found     <= 1'b0;
         bus.framing_error <= 1'b0;
         bus.parse_error   <= 1'b0;
      end else begin
         bus.frame_valid   <= emit;
         bus.framing_error <= stop_low;
         bus.parse_error   <= p_fail || (stop_low && in_frame);
         p_state           <= (stop_low && in_frame) ? P_ERR : p_next;
         if (restart) begin
            line_cnt <= LW'(1);
            st_t     <= '0;
            st_key   <= '0;
            st_found <= 1'b0;
            t_seen   <= 1'b0;
         end else if (byte_valid) begin
            if (in_frame) line_cnt <= line_cnt + 1'b1;
            case (p_state)
               P_KEY_Q: key_len <= '0;
               P_KEY: begin
                  if (shreg != CH_QUOTE) begin
                     if (key_len == 2'd0) key_char <= shreg;
                     if (key_len != 2'd2) key_len <= key_len + 1'b1;
                  end
               end
               P_COLON: begin
                  acc        <= '0;
                  neg        <= 1'b0;
                  digit_seen <= 1'b0;
                  val_first  <= 1'b1;
               end
               P_VALUE: begin
                  val_first <= 1'b0;
                  if (is_digit) begin
                     acc        <= acc_sat;
                     digit_seen <= 1'b1;
                  end
                  if (shreg == CH_MINUS && val_first) neg <= 1'b1;
               end
               default: ;
            endcase
            if (do_commit && match_t) begin
               st_t   <= acc;
               t_seen <= 1'b1;
            end
            if (do_commit && match_k) begin
               st_key   <= neg ? (~acc + 16'd1) : acc;
               st_found <= 1'b1;
            end
         end
         if (emit) begin
            bus.t_code    <= st_t;
            bus.key_found <= st_found;
            if (st_found) bus.key_value <= st_key;
         end
      end
   end

endmodule

// File: tb/tb_uart_json_feedback_rx.sv
// Self-checking bench: serialises JSON lines into the receiver and scores
// frame outputs against a queue of expected frames plus error-pulse counts.
module tb_uart_json_feedback_rx;

   localparam int unsigned CPB = 16;
   localparam int NV = 11;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   uart_json_feedback_rx_if bus ();

   uart_json_feedback_rx #(
      .CLKS_PER_BIT(CPB),
      .KEY_CHAR    (8'h76),
      .MAX_LEN     (255)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [15:0] t;
      logic [15:0] kv;
      logic        kf;
   } exp_t;

   typedef struct {
      string       line;
      bit          valid;
      logic [15:0] t;
      logic [15:0] kv;
      logic        kf;
      int          perr;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[NV];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   fv_cnt = 0;
   int   perr_cnt = 0;
   int   ferr_cnt = 0;
   bit   fe_had_pe = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (bus.parse_error) perr_cnt++;
         if (bus.framing_error) begin
            ferr_cnt++;
            fe_had_pe = bus.parse_error;
         end
         if (bus.frame_valid) begin
            fv_cnt++;
            check("frame_expected", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               exp_t e;
               e = exp_q.pop_front();
               check("t_code", 64'(bus.t_code), 64'(e.t));
               check("key_value", 64'(bus.key_value), 64'(e.kv));
               check("key_found", 64'(bus.key_found), 64'(e.kf));
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      bus.uart_in = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.uart_in = b[i];
         repeat (CPB) @(posedge clk);
      end
      bus.uart_in = stop_ok;
      repeat (CPB) @(posedge clk);
      bus.uart_in = 1'b1;
      if (!stop_ok) repeat (2 * CPB) @(posedge clk);
   endtask

   task automatic send_line(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
   endtask

   function automatic logic [63:0] all_outputs();
      return 64'({bus.frame_valid, bus.t_code, bus.key_value, bus.key_found,
                  bus.framing_error, bus.parse_error});
   endfunction

   int p0, f0, e0;

   initial begin
      bus.uart_in = 1'b1;
      rst = 1'b0;

      vecs[0]  = '{"{\"T\":1001,\"L\":0.5,\"v\":12.03}\n", 1'b1, 16'd1001, 16'd1203, 1'b1, 0};
      vecs[1]  = '{"{\"T\":1,\"v\":-5}\n",                 1'b1, 16'd1,    16'hFFFB,  1'b1, 0};
      vecs[2]  = '{"{\"T\":7,\"L\":3}\n",                  1'b1, 16'd7,    16'hFFFB,  1'b0, 0};
      vecs[3]  = '{"{\"T\":2,\"v\":99999}\n",              1'b1, 16'd2,    16'h7FFF,  1'b1, 0};
      vecs[4]  = '{"{\"T\"1}\n",                           1'b0, 16'd0,    16'd0,     1'b0, 1};
      vecs[5]  = '{"{\"T\":4,\"v\":-0.25}\n",              1'b1, 16'd4,    16'hFFE7,  1'b1, 0};
      vecs[6]  = '{"{\"v\":3}\n",                          1'b0, 16'd0,    16'd0,     1'b0, 1};
      vecs[7]  = '{"{\"T\":5,\"v\":}\n",                   1'b0, 16'd0,    16'd0,     1'b0, 1};
      vecs[8]  = '{"{\"T\":65535,\"v\":0}\n",              1'b1, 16'h7FFF, 16'd0,     1'b1, 0};
      vecs[9]  = '{"{\"T\":3,{\"T\":4,\"v\":1}\n",         1'b1, 16'd4,    16'd1,     1'b1, 0};
      vecs[10] = '{"\n\n{\"T\":6}\n",                      1'b1, 16'd6,    16'd1,     1'b0, 0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", all_outputs(), 64'(0));
      rst = 1'b1;
      repeat (4 * CPB) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         p0 = perr_cnt;
         f0 = fv_cnt;
         e0 = ferr_cnt;
         if (vecs[i].valid) exp_q.push_back('{t: vecs[i].t, kv: vecs[i].kv, kf: vecs[i].kf});
         send_line(vecs[i].line);
         repeat (2 * CPB) @(posedge clk);
         check($sformatf("v%0d_pending", i), 64'(exp_q.size()), 64'(0));
         check($sformatf("v%0d_frames", i), 64'(fv_cnt - f0), 64'(vecs[i].valid));
         check($sformatf("v%0d_parse_err", i), 64'(perr_cnt - p0), 64'(vecs[i].perr));
         check($sformatf("v%0d_framing_err", i), 64'(ferr_cnt - e0), 64'(0));
         exp_q.delete();
      end

      // Bad stop bit in the middle of a line, then a clean line.
      p0 = perr_cnt;
      f0 = fv_cnt;
      e0 = ferr_cnt;
      fe_had_pe = 1'b0;
      send_line("{\"T\":1");
      send_byte(8'h2C, 1'b0);
      send_line("}\n");
      repeat (2 * CPB) @(posedge clk);
      check("fe_framing_err", 64'(ferr_cnt - e0), 64'(1));
      check("fe_parse_err", 64'(perr_cnt - p0), 64'(1));
      check("fe_same_cycle", 64'(fe_had_pe), 64'(1));
      check("fe_frames", 64'(fv_cnt - f0), 64'(0));
      exp_q.push_back('{t: 16'd11, kv: 16'd2, kf: 1'b1});
      send_line("{\"T\":11,\"v\":2}\n");
      repeat (2 * CPB) @(posedge clk);
      check("fe_recover_pending", 64'(exp_q.size()), 64'(0));
      exp_q.delete();

      // Reset in the middle of a line.
      f0 = fv_cnt;
      send_line("{\"T\":12,\"v\":");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midreset_outputs_a", all_outputs(), 64'(0));
      repeat (2) @(negedge clk);
      check("midreset_outputs_b", all_outputs(), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      repeat (4 * CPB) @(posedge clk);
      exp_q.push_back('{t: 16'd13, kv: 16'd0, kf: 1'b0});
      send_line("}\n{\"T\":13}\n");
      repeat (2 * CPB) @(posedge clk);
      check("midreset_pending", 64'(exp_q.size()), 64'(0));
      check("midreset_frames", 64'(fv_cnt - f0), 64'(1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_json_feedback_rx.md
Name: uart_json_feedback_rx

Overview:
- Receive-side counterpart of the rover command path. Deserialises the rover's UART feedback line (8N1) and parses one flat JSON object per line, e.g. {"T":1001,"L":-0.1,"v":12.03}\n.
- Extracts the integer "T" code and the value of one configurable single-character key, then presents both on a one-cycle frame_valid strobe to the motor-control FSM (battery, odometry and speed monitoring).

Parameters:
- CLKS_PER_BIT, 50_000_000/115_200, clock cycles per UART bit.
- KEY_CHAR, 8'h76 ("v"), single-character key whose value is extracted.
- MAX_LEN, 255, maximum bytes per line before the line is declared malformed.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- uart_in  input  1  serial RX line, asynchronous to clk, idle high.
- frame_valid  output  1  one-cycle pulse: a complete well-formed line was parsed.
- t_code  output  16  unsigned value of "T" from the last valid frame.
- key_value  output  16  signed two's-complement value of KEY_CHAR from the last valid frame.
- key_found  output  1  KEY_CHAR was present in the last valid frame.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- parse_error  output  1  one-cycle pulse: line rejected.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, UART RX in IDLE, parser in WAIT_OPEN, accumulators cleared. Release is synchronous to clk.
- uart_in passes through a 2-flop synchroniser before use.
- UART RX FSM:
  - IDLE -> START on a synchronised falling edge.
  - START: at CLKS_PER_BIT/2, line low -> DATA; line high -> IDLE (glitch rejected).
  - DATA: sample every CLKS_PER_BIT, 8 bits, LSB first.
  - STOP: sample at mid-bit. High -> internal byte_valid pulse. Low -> framing_error pulse and byte discarded. Both return to IDLE.
- Parser FSM (advances only on byte_valid):
  - WAIT_OPEN: "{" -> KEY_Q; anything else is ignored.
  - KEY_Q: '"' -> KEY.
  - KEY: first char is captured and key length counted; '"' -> COLON. Key matches only if length == 1.
  - COLON: ":" -> VALUE. Clear the accumulator, sign flag and digit seen flag.
  - VALUE:
    - Leading "-" sets negative (first char only).
    - "0"-"9": acc = acc*10 + digit, saturating at 32767.
    - "." is ignored, so 12.03 -> 1203.
    - "," -> commit, then KEY_Q.
    - "}" -> commit, then WAIT_NL.
    - Commit requires at least one digit.
  - WAIT_NL: 0x0A -> emit; extra 0x0A bytes while in WAIT_OPEN are ignored.
  - ERR: wait for 0x0A, then WAIT_OPEN.
- Commit rules:
  - Key "T": staged t_code = acc (unsigned 16 bit; sign ignored).
  - Key KEY_CHAR: staged key_value = negative ? -acc : acc; staged key_found = 1.
  - Other keys are discarded.
- Emit: frame_valid pulses the cycle after the byte_valid of the terminating 0x0A. t_code, key_value and key_found update in that same cycle and hold until the next valid frame.
  - A frame without a "T" key is treated as malformed.
  - If KEY_CHAR is absent, key_found = 0 and key_value holds its previous value.
- Malformed line: parse_error pulses once and the parser enters ERR. Any of the following is malformed:
  - an unexpected character in any non-WAIT_OPEN state;
  - a value with no digits;
  - a missing "T";
  - line byte count reaching MAX_LEN.
- "{" received in any state other than WAIT_OPEN or ERR restarts the frame (staging cleared) without parse_error.
- A framing_error inside a frame forces ERR and raises parse_error in the same cycle.
- Reset mid-frame discards all staging; outputs read 0.

Test Plan:
- Send {"T":1001,"L":0.5,"v":12.03}\n at 115200 baud -> one frame_valid, t_code=1001, key_value=1203, key_found=1, no error pulses.
- Send {"T":1,"v":-5}\n -> t_code=1, key_value=16'hFFFB, key_found=1. Then send {"T":7,"L":3}\n -> t_code=7, key_found=0, key_value stays 16'hFFFB.
- Send {"T":2,"v":99999}\n -> key_value=32767 (saturated).
- Send {"T"1}\n -> parse_error pulses once, no frame_valid. The next valid line parses correctly.
- Drive a byte with the stop bit low in the middle of a line -> framing_error and parse_error pulse, no frame_valid for that line.
- Assert rst low mid-line for 3 cycles, then send a full valid line -> all outputs 0 during reset, and only the post-reset line produces frame_valid.
